// File: rtl/ibex_fp_wb_arbiter.sv
// rtl/ibex_fp_wb_arbiter.sv - FP register file write-port arbiter with pending-register scoreboard
// Merges fixed-timing FLW load data and buffered FPU results into one registered write stream.
module ibex_fp_wb_arbiter #(
  parameter int DataWidth    = 32,
  parameter int FpuFifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  output logic                 issue_ready_o,
  input  logic [4:0]           chk_rs1_i,
  input  logic [4:0]           chk_rs2_i,
  input  logic [4:0]           chk_rs3_i,
  input  logic [2:0]           chk_en_i,
  output logic                 hazard_o,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [4:0]           fpu_rd_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_rd_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic [4:0]           fp_waddr_a_o,
  output logic [DataWidth-1:0] fp_wdata_a_o,
  output logic                 fp_we_a_o,
  output logic                 idle_o,
  output logic                 err_o
);

  localparam int PtrW = (FpuFifoDepth > 1) ? $clog2(FpuFifoDepth) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FpuFifoDepth);

  logic [4:0]           fifo_rd_q   [FpuFifoDepth];
  logic [DataWidth-1:0] fifo_data_q [FpuFifoDepth];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      cnt_q;

  logic [31:0]          pend_q, pend_d;
  logic                 we_q;
  logic [4:0]           waddr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 err_q;

  logic                 fifo_empty, fpu_push, fifo_wr, fifo_pop, bypass;
  logic                 sel_valid;
  logic [4:0]           sel_rd;
  logic [DataWidth-1:0] sel_data;

  assign fifo_empty  = (cnt_q == '0);
  assign fpu_ready_o = (cnt_q != FullCnt);
  assign fpu_push    = fpu_valid_i && fpu_ready_o;

  // LSU cannot stall, so it always wins; FPU results keep their acceptance order.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    fifo_pop  = 1'b0;
    bypass    = 1'b0;
    if (lsu_valid_i) begin
      sel_valid = 1'b1;
      sel_rd    = lsu_rd_i;
      sel_data  = lsu_wdata_i;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd_q[rptr_q];
      sel_data  = fifo_data_q[rptr_q];
      fifo_pop  = 1'b1;
    end else if (fpu_push) begin
      sel_valid = 1'b1;
      sel_rd    = fpu_rd_i;
      sel_data  = fpu_wdata_i;
      bypass    = 1'b1;
    end
  end

  assign fifo_wr = fpu_push && !bypass;

  always_comb begin
    pend_d = pend_q;
    if (we_q) begin
      pend_d[waddr_q] = 1'b0;
    end
    if (issue_valid_i && issue_ready_o) begin
      pend_d[issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) begin
      fifo_rd_q[wptr_q]   <= fpu_rd_i;
      fifo_data_q[wptr_q] <= fpu_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (fifo_wr) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (fifo_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      cnt_q  <= cnt_q + CntW'(fifo_wr) - CntW'(fifo_pop);
      pend_q <= pend_d;
      we_q   <= sel_valid;
      if (sel_valid) begin
        waddr_q <= sel_rd;
        wdata_q <= sel_data;
      end
      err_q <= we_q && !pend_q[waddr_q];
    end
  end

  assign issue_ready_o = !pend_q[issue_rd_i];
  assign hazard_o      = (chk_en_i[0] && pend_q[chk_rs1_i]) ||
                         (chk_en_i[1] && pend_q[chk_rs2_i]) ||
                         (chk_en_i[2] && pend_q[chk_rs3_i]);
  assign idle_o        = (pend_q == '0) && fifo_empty && !we_q;
  assign fp_we_a_o     = we_q;
  assign fp_waddr_a_o  = waddr_q;
  assign fp_wdata_a_o  = wdata_q;
  assign err_o         = err_q;

endmodule

// File: doc/ibex_fp_wb_arbiter.md
Name: ibex_fp_wb_arbiter

Overview:
- Write-side initiator for the FP register file's single write port.
- Merges two result sources into one registered write stream (fp_waddr/fp_wdata/fp_we) and tracks pending FP destination registers in a 32-entry scoreboard:
  - FPU results: multi-cycle, back-pressurable.
  - LSU FLW load data: fixed timing, cannot stall.
- Decode uses the scoreboard for RAW/WAW hazard stalls.

Parameters:
- DataWidth, 32, width of FP register data.
- FpuFifoDepth, 2, FPU result buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- issue_valid_i  in  1  decode issues an instruction with an FP destination.
- issue_rd_i  in  5  FP destination of the issuing instruction.
- issue_ready_o  out  1  issue accepted, i.e. no WAW on issue_rd_i.
- chk_rs1_i, chk_rs2_i, chk_rs3_i  in  5 each  FP sources to hazard-check.
- chk_en_i  in  3  per-source check enables, bit0 = rs1.
- hazard_o  out  1  an enabled source is pending.
- fpu_valid_i  in  1  FPU result valid.
- fpu_ready_o  out  1  FPU result accepted.
- fpu_rd_i  in  5  FPU result destination.
- fpu_wdata_i  in  DataWidth  FPU result data.
- lsu_valid_i  in  1  FLW data valid; always accepted.
- lsu_rd_i  in  5  FLW destination.
- lsu_wdata_i  in  DataWidth  FLW data.
- fp_waddr_a_o  out  5  regfile write address.
- fp_wdata_a_o  out  DataWidth  regfile write data.
- fp_we_a_o  out  1  regfile write enable.
- idle_o  out  1  no pending registers and FIFO empty.
- err_o  out  1  one-cycle pulse: write to a non-pending register.

Behaviour:
- Reset values: scoreboard all 0, FIFO empty, fp_we_a_o=0, fp_waddr_a_o=0, fp_wdata_a_o=0, err_o=0, idle_o=1.
- Reset asserted mid-operation discards FIFO contents and pending bits. The in-flight registered write is squashed: fp_we_a_o=0 in the cycle after rst_i is sampled.
- FIFO:
  - Circular, read and write pointers of clog2(FpuFifoDepth) bits that wrap modulo depth; count register of width clog2(FpuFifoDepth)+1.
  - fpu_ready_o = (count != FpuFifoDepth), computed from registered state only.
  - Push on fpu_valid_i && fpu_ready_o.
- Selection each cycle, combinational:
  - If lsu_valid_i: select LSU.
  - Else if FIFO not empty: select FIFO head and pop.
  - Else if the FPU is pushing into the empty FIFO: bypass, select the incoming FPU data, no FIFO write.
  - Else: no write.
  - When LSU is selected and the FPU pushes, the FPU entry enters the FIFO.
- Write port: the selected entry is registered. Source-accept cycle N gives fp_we_a_o=1 in cycle N+1. Minimum latency 1 cycle (LSU, or FPU bypass).
- In-order rule: FPU results leave in acceptance order. LSU may overtake buffered FPU results.
- Scoreboard:
  - issue_ready_o = !pend[issue_rd_i].
  - Set pend[issue_rd_i] on issue_valid_i && issue_ready_o.
  - Clear pend[fp_waddr_a_o] in the cycle fp_we_a_o=1.
  - Set and clear of the same register in one cycle: set wins.
  - Scoreboard is updated at the clock edge; hazard_o and issue_ready_o see the updated value the next cycle.
- hazard_o = OR over enabled k of pend[chk_rsk_i]. Combinational from registered pend; no bypass from the current write.
- err_o: registered pulse, high in cycle N+1 when fp_we_a_o=1 in cycle N and pend[fp_waddr_a_o]=0 in cycle N. The write still proceeds.
- idle_o = (pend == 0) && FIFO empty && !fp_we_a_o.
- All 32 registers are writable and trackable; f0 is an ordinary register.

Test Plan:
- Reset, then issue rd=3; two cycles later FPU result rd=3, data 0x3F800000:
  - issue_ready_o=1, then pend[3]=1 and hazard_o=1 for chk_rs1=3, chk_en=001.
  - FPU accepted by bypass; next cycle fp_we_a_o=1, waddr=3, wdata=0x3F800000.
  - Following cycle hazard_o=0 and idle_o=1.
- Collision, LSU has priority: issue rd=5 and rd=6; same cycle lsu_valid rd=5 data 0x11111111 and fpu_valid rd=6 data 0x22222222:
  - Cycle+1: write rd5 0x11111111.
  - Cycle+2: write rd6 0x22222222.
- FIFO full: hold lsu_valid_i=1 for 4 cycles while the FPU offers 3 results (rd 8, 9, 10):
  - fpu_ready_o drops after 2 accepts.
  - After LSU stops, writes appear 8, 9, then 10 (accepted once space frees). No loss, no duplication, pointer wrap exercised.
- WAW stall: pend[12]=1 and issue rd=12 -> issue_ready_o=0, held until the cycle after the rd12 write, then 1.
- Set-wins: FPU writes rd=7 while a new issue of rd=7 is accepted in the same cycle (pend[7] was cleared the cycle before) -> pend[7]=1 afterwards, hazard_o=1 on rs2=7.
- Spurious write: LSU rd=20 with pend[20]=0 -> write occurs and err_o pulses for one cycle. rst_i asserted with 2 FIFO entries -> no further writes, idle_o=1.
